// File: rtl/rf_wb_arbiter.sv
// Two-port register-file writeback arbiter with starvation-based priority swap
// and a busy scoreboard that flags decode-stage source hazards.
module rf_wb_arbiter #(
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_CODE_LENGTH = 5,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p0_valid,
    input  logic [REG_CODE_LENGTH-1:0] p0_rd,
    input  logic [REG_DATA_WIDTH-1:0]  p0_data,
    output logic                       p0_ready,
    input  logic                       p1_valid,
    input  logic [REG_CODE_LENGTH-1:0] p1_rd,
    input  logic [REG_DATA_WIDTH-1:0]  p1_data,
    output logic                       p1_ready,
    input  logic                       iss_valid,
    input  logic [REG_CODE_LENGTH-1:0] iss_rd,
    input  logic [REG_CODE_LENGTH-1:0] chk_rs1,
    input  logic [REG_CODE_LENGTH-1:0] chk_rs2,
    output logic                       stall,
    output logic                       RegWrite,
    output logic [REG_CODE_LENGTH-1:0] w_rg,
    output logic [REG_DATA_WIDTH-1:0]  w_data
);

    localparam int NUM_REGS = 2 ** REG_CODE_LENGTH;
    localparam int CNT_W    = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0]           CNT_SAT  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [REG_CODE_LENGTH-1:0] ZERO_RD  = {REG_CODE_LENGTH{1'b0}};

    typedef enum logic [0:0] {
        P0_PRI = 1'b0,
        P1_PRI = 1'b1
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_nxt_s;
    logic [NUM_REGS-1:0]         busy_r;
    logic [NUM_REGS-1:0]         busy_nxt_s;
    logic                        p0_ready_s;
    logic                        p1_ready_s;
    logic                        p0_xfer_s;
    logic                        p1_xfer_s;
    logic                        stall_s;
    logic                        we_r;
    logic [REG_CODE_LENGTH-1:0]  rg_r;
    logic [REG_DATA_WIDTH-1:0]   data_r;

    assign p0_xfer_s = p0_valid && p0_ready_s;
    assign p1_xfer_s = p1_valid && p1_ready_s;
    assign p0_ready  = p0_ready_s;
    assign p1_ready  = p1_ready_s;
    assign stall     = stall_s;
    assign RegWrite  = we_r;
    assign w_rg      = rg_r;
    assign w_data    = data_r;

    // Ready generation: the priority port is always ready, the other only when the priority port is idle.
    always_comb begin
        p0_ready_s = 1'b0;
        p1_ready_s = 1'b0;
        if (rst) begin
            p0_ready_s = 1'b0;
            p1_ready_s = 1'b0;
        end else begin
            case (state_r)
                P0_PRI: begin
                    p0_ready_s = 1'b1;
                    p1_ready_s = !p0_valid;
                end
                P1_PRI: begin
                    p1_ready_s = 1'b1;
                    p0_ready_s = !p1_valid;
                end
                default: begin
                    p0_ready_s = 1'b0;
                    p1_ready_s = 1'b0;
                end
            endcase
        end
    end

    // Starvation counter and priority FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (p1_xfer_s || !p1_valid) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = P0_PRI;
        end else if (!p1_ready_s) begin
            if (cnt_r != CNT_SAT) begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_nxt_s = cnt_r;
            end
            // Swap on the edge that records the STARVE_LIMIT-th consecutive denial.
            if ((state_r == P0_PRI) && (cnt_r == CNT_LAST)) begin
                state_nxt_s = P1_PRI;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            cnt_nxt_s   = cnt_r;
            state_nxt_s = state_r;
        end
    end

    // Scoreboard next value: clear on long-latency writeback, then set on issue so set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (p1_xfer_s) begin
            busy_nxt_s[p1_rd] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (iss_valid && (iss_rd != ZERO_RD)) begin
            busy_nxt_s[iss_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Source hazard check against the registered scoreboard only.
    always_comb begin
        stall_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((chk_rs1 != ZERO_RD) && busy_r[chk_rs1]) ||
                      ((chk_rs2 != ZERO_RD) && busy_r[chk_rs2]);
        end
    end

    // Arbitration and scoreboard state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= P0_PRI;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= {NUM_REGS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Registered register-file write port; a transfer to x0 completes but does not write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r   <= 1'b0;
            rg_r   <= ZERO_RD;
            data_r <= {REG_DATA_WIDTH{1'b0}};
        end else if (p0_xfer_s) begin
            we_r   <= (p0_rd != ZERO_RD);
            rg_r   <= p0_rd;
            data_r <= p0_data;
        end else if (p1_xfer_s) begin
            we_r   <= (p1_rd != ZERO_RD);
            rg_r   <= p1_rd;
            data_r <= p1_data;
        end else begin
            we_r   <= 1'b0;
            rg_r   <= rg_r;
            data_r <= data_r;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_rf_wb_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid;
    logic [4:0]  p0_rd;
    logic [31:0] p0_data;
    logic        p0_ready;
    logic        p1_valid;
    logic [4:0]  p1_rd;
    logic [31:0] p1_data;
    logic        p1_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  w_rg;
    logic [31:0] w_data;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    bit          m_p1pri;
    int          m_denied;
    bit [31:0]   m_busy;
    bit          m_we;
    bit [4:0]    m_rg;
    bit [31:0]   m_data;
    bit          x0_last;
    bit          x1_last;

    rf_wb_arbiter #(
        .REG_DATA_WIDTH (32),
        .REG_CODE_LENGTH(5),
        .STARVE_LIMIT   (STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid),
        .p0_rd    (p0_rd),
        .p0_data  (p0_data),
        .p0_ready (p0_ready),
        .p1_valid (p1_valid),
        .p1_rd    (p1_rd),
        .p1_data  (p1_data),
        .p1_ready (p1_ready),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .stall    (stall),
        .RegWrite (RegWrite),
        .w_rg     (w_rg),
        .w_data   (w_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs applied: checks, clocks once, advances the model.
    task automatic step();
        bit er0, er1, est, x0, x1;
        #1;
        if (rst) begin
            er0 = 1'b0; er1 = 1'b0; est = 1'b0;
        end else begin
            er0 = m_p1pri ? !p1_valid : 1'b1;
            er1 = m_p1pri ? 1'b1 : !p0_valid;
            est = (chk_rs1 != 5'd0 && m_busy[chk_rs1]) || (chk_rs2 != 5'd0 && m_busy[chk_rs2]);
        end
        check_val("p0_ready", 32'(p0_ready), 32'(er0));
        check_val("p1_ready", 32'(p1_ready), 32'(er1));
        check_val("stall",    32'(stall),    32'(est));
        check_val("RegWrite", 32'(RegWrite), 32'(m_we));
        if (m_we) begin
            check_val("w_rg",   32'(w_rg), 32'(m_rg));
            check_val("w_data", w_data,    m_data);
        end
        @(posedge clk);
        if (rst) begin
            m_p1pri = 1'b0; m_denied = 0; m_busy = '0;
            m_we = 1'b0; m_rg = '0; m_data = '0;
            x0 = 1'b0; x1 = 1'b0;
        end else begin
            x0 = p0_valid && er0;
            x1 = p1_valid && er1;
            if (x0) begin
                m_we = (p0_rd != 5'd0); m_rg = p0_rd; m_data = p0_data;
            end else if (x1) begin
                m_we = (p1_rd != 5'd0); m_rg = p1_rd; m_data = p1_data;
            end else begin
                m_we = 1'b0;
            end
            if (x1) m_busy[p1_rd] = 1'b0;
            if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            if (x1 || !p1_valid) begin
                m_denied = 0;
                m_p1pri  = 1'b0;
            end else begin
                m_denied++;
                if (m_denied >= STARVE_LIMIT) m_p1pri = 1'b1;
            end
        end
        x0_last = x0;
        x1_last = x1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        p0_valid = 1'b0; p0_rd = '0; p0_data = '0;
        p1_valid = 1'b0; p1_rd = '0; p1_data = '0;
        iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
        m_p1pri = 1'b0; m_denied = 0; m_busy = '0;
        m_we = 1'b0; m_rg = '0; m_data = '0; x0_last = 1'b0; x1_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step();
        check_val("rst_RegWrite", 32'(RegWrite), 32'd0);
        check_val("rst_w_rg",     32'(w_rg),     32'd0);
        check_val("rst_w_data",   w_data,        32'd0);
        rst = 1'b0;
        step();

        // Simple ALU writeback
        p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'hDEADBEEF;
        #1 check_val("alu_ready", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 1'b0;
        check_val("alu_we",   32'(RegWrite), 32'd1);
        check_val("alu_rg",   32'(w_rg),     32'd5);
        check_val("alu_data", w_data,        32'hDEADBEEF);
        step();

        // Starvation: p1 denied four cycles, then wins
        p0_rd = 5'd1; p0_data = 32'h0000_0011;
        p1_rd = 5'd7; p1_data = 32'h7777_0007;
        for (int c = 0; c < 5; c++) begin
            p0_valid = 1'b1; p1_valid = 1'b1;
            #1;
            if (c < 4) begin
                check_val("starve_p1_denied", 32'(p1_ready), 32'd0);
            end else begin
                check_val("starve_p1_wins", 32'(p1_ready), 32'd1);
                check_val("starve_p0_held", 32'(p0_ready), 32'd0);
            end
            step();
        end
        p1_rd = 5'd8;
        check_val("starve_we",   32'(RegWrite), 32'd1);
        check_val("starve_rg",   32'(w_rg),     32'd7);
        check_val("starve_data", w_data,        32'h7777_0007);
        #1 check_val("starve_back_p0pri", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 1'b0; p1_valid = 1'b0;
        step();

        // Scoreboard set, hazard, clear
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0; chk_rs1 = 5'd9;
        #1 check_val("sb_stall_set", 32'(stall), 32'd1);
        step();
        p1_valid = 1'b1; p1_rd = 5'd9; p1_data = 32'h9999_0009;
        #1 check_val("sb_stall_same_cycle", 32'(stall), 32'd1);
        step();
        p1_valid = 1'b0;
        #1 check_val("sb_stall_cleared", 32'(stall), 32'd0);
        step();

        // Same-edge issue and writeback of one index: set wins
        chk_rs1 = 5'd0; chk_rs2 = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        p1_valid = 1'b1; p1_rd = 5'd9;
        step();
        iss_valid = 1'b0; p1_valid = 1'b0;
        #1 check_val("sb_set_wins", 32'(stall), 32'd1);
        step();
        p1_valid = 1'b1;
        step();
        p1_valid = 1'b0; chk_rs2 = 5'd0;

        // Writes and issues to x0
        p0_valid = 1'b1; p0_rd = 5'd0; p0_data = 32'h0000_1234;
        #1 check_val("x0_ready", 32'(p0_ready), 32'd1);
        step();
        p0_valid = 1'b0;
        check_val("x0_no_write", 32'(RegWrite), 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0; chk_rs1 = 5'd0;
        #1 check_val("x0_no_stall", 32'(stall), 32'd0);
        step();

        // Reset in the middle of arbitration
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_valid = 1'b0;
        p0_valid = 1'b1; p0_rd = 5'd4; p0_data = 32'h0000_4444;
        p1_valid = 1'b1; p1_rd = 5'd3; p1_data = 32'h0000_3333;
        repeat (4) step();
        check_val("mid_we_before", 32'(RegWrite), 32'd1);
        rst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6; chk_rs1 = 5'd3;
        #1;
        check_val("mid_rst_p0_ready", 32'(p0_ready), 32'd0);
        check_val("mid_rst_p1_ready", 32'(p1_ready), 32'd0);
        check_val("mid_rst_stall",    32'(stall),    32'd0);
        step();
        check_val("mid_rst_we",   32'(RegWrite), 32'd0);
        check_val("mid_rst_rg",   32'(w_rg),     32'd0);
        check_val("mid_rst_data", w_data,        32'd0);
        rst = 1'b0; iss_valid = 1'b0;
        #1;
        check_val("mid_post_stall",   32'(stall),    32'd0);
        check_val("mid_post_p0pri",   32'(p0_ready), 32'd1);
        check_val("mid_post_p1_wait", 32'(p1_ready), 32'd0);
        step();
        p0_valid = 1'b0; p1_valid = 1'b0;
        step();

        // Random traffic; requesters hold their request until it transfers
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!p0_valid || x0_last) begin
                p0_valid = ($urandom_range(0, 2) != 0);
                p0_rd    = 5'($urandom_range(0, 7));
                p0_data  = $urandom;
            end
            if (!p1_valid || x1_last) begin
                p1_valid = ($urandom_range(0, 1) != 0);
                p1_rd    = 5'($urandom_range(0, 7));
                p1_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 7));
            chk_rs1   = 5'($urandom_range(0, 7));
            chk_rs2   = 5'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
